// File: rtl/time_sync_phc_arb.sv
// Round-robin arbiter from per-interface ToD write requests onto one held PHC write port.
// Define TIME_SYNC_PHC_TIMEOUT_EN to abandon writes not acked within ACK_TIMEOUT_CYCLES.
module time_sync_phc_arb #(
    parameter int IF_COUNT           = 2,
    parameter int HOLDOFF_CYCLES     = 16,
    parameter int ACK_TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IF_COUNT-1:0]    sync_wr_en,
    input  logic [IF_COUNT*96-1:0] sync_wr_ts,
    output logic                   time_sync_wr_en,
    output logic [29:0]            time_sync_wr_ns,
    output logic [47:0]            time_sync_wr_s,
    input  logic                   time_sync_wr_ack,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   stat_wr_count,
    output logic [CNT_WIDTH-1:0]   stat_drop_count,
    output logic [CNT_WIDTH-1:0]   stat_reject_count,
    output logic                   stat_timeout
);
    localparam int IDX_W = (IF_COUNT > 1) ? $clog2(IF_COUNT) : 1;
    localparam int GAP_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int EVT_W = $clog2(IF_COUNT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [29:0] NS_LIMIT = 30'd1_000_000_000;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t                     state_q, state_d;
    logic [IF_COUNT-1:0]        pending_q, pending_d;
    logic [IF_COUNT-1:0][47:0]  slot_s_q;
    logic [IF_COUNT-1:0][29:0]  slot_ns_q;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic                       wr_en_q, wr_en_d;
    logic [29:0]                wr_ns_q, wr_ns_d;
    logic [47:0]                wr_s_q, wr_s_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [CNT_WIDTH-1:0]       wr_cnt_q, drop_cnt_q, rej_cnt_q;

    logic [IF_COUNT-1:0][47:0]  cap_s;
    logic [IF_COUNT-1:0][29:0]  cap_ns;
    logic [IF_COUNT-1:0]        cap_ok, cap_bad;
    logic                       grant_found, grant_fire, wr_done;
    logic [IDX_W-1:0]           grant_idx, cand;
    logic [EVT_W-1:0]           n_drop, n_rej;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [EVT_W-1:0]     n);
        logic [CNT_WIDTH+EVT_W-1:0] sum;
        sum = (CNT_WIDTH+EVT_W)'(c) + (CNT_WIDTH+EVT_W)'(n);
        return (|sum[CNT_WIDTH+EVT_W-1:CNT_WIDTH]) ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // fns and ts[47:46] never reach the PHC
    logic [IF_COUNT-1:0] unused_ts;
    for (genvar g = 0; g < IF_COUNT; g++) begin : g_unused
        assign unused_ts[g] = ^{sync_wr_ts[g*96+46 +: 2], sync_wr_ts[g*96 +: 16]};
    end

    always_comb begin
        for (int i = 0; i < IF_COUNT; i++) begin
            cap_s[i]   = sync_wr_ts[i*96+48 +: 48];
            cap_ns[i]  = sync_wr_ts[i*96+16 +: 30];
            cap_ok[i]  = sync_wr_en[i] && (cap_ns[i] < NS_LIMIT);
            cap_bad[i] = sync_wr_en[i] && !(cap_ns[i] < NS_LIMIT);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = '0;
        for (int k = 1; k <= IF_COUNT; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % IF_COUNT);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && grant_found;

    // A capture landing on the slot being granted this cycle is a fresh request, not a drop
    always_comb begin
        pending_d = pending_q;
        n_drop    = '0;
        n_rej     = '0;
        if (grant_fire) pending_d[grant_idx] = 1'b0;
        for (int i = 0; i < IF_COUNT; i++) begin
            if (cap_ok[i]) begin
                if (pending_q[i] && !(grant_fire && grant_idx == IDX_W'(i)))
                    n_drop = n_drop + EVT_W'(1);
                pending_d[i] = 1'b1;
            end
            if (cap_bad[i]) n_rej = n_rej + EVT_W'(1);
        end
    end

`ifdef TIME_SYNC_PHC_TIMEOUT_EN
    localparam int TMO_W = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tcnt_q, tcnt_d;
    logic             tmo_q, tmo_d;
`else
    logic unused_tmo_param;
    assign unused_tmo_param = (ACK_TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d      = state_q;
        wr_en_d      = wr_en_q;
        wr_ns_d      = wr_ns_q;
        wr_s_d       = wr_s_q;
        last_grant_d = last_grant_q;
        gap_d        = gap_q;
        wr_done      = 1'b0;
`ifdef TIME_SYNC_PHC_TIMEOUT_EN
        tcnt_d       = tcnt_q;
        tmo_d        = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    wr_en_d      = 1'b1;
                    wr_ns_d      = slot_ns_q[grant_idx];
                    wr_s_d       = slot_s_q[grant_idx];
                    last_grant_d = grant_idx;
                    state_d      = ISSUE;
`ifdef TIME_SYNC_PHC_TIMEOUT_EN
                    tcnt_d       = '0;
`endif
                end
            end
            ISSUE: begin
                if (time_sync_wr_ack) begin
                    wr_en_d = 1'b0;
                    wr_done = 1'b1;
                    gap_d   = '0;
                    state_d = (HOLDOFF_CYCLES == 0) ? IDLE : GAP;
                end
`ifdef TIME_SYNC_PHC_TIMEOUT_EN
                else if (tcnt_q == TMO_LAST) begin
                    wr_en_d = 1'b0;
                    tmo_d   = 1'b1;
                    gap_d   = '0;
                    state_d = (HOLDOFF_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    tcnt_d = tcnt_q + TMO_W'(1);
                end
`endif
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            slot_s_q     <= '0;
            slot_ns_q    <= '0;
            last_grant_q <= IDX_W'(IF_COUNT - 1);
            wr_en_q      <= 1'b0;
            wr_ns_q      <= '0;
            wr_s_q       <= '0;
            gap_q        <= '0;
            wr_cnt_q     <= '0;
            drop_cnt_q   <= '0;
            rej_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_ns_q      <= wr_ns_d;
            wr_s_q       <= wr_s_d;
            gap_q        <= gap_d;
            wr_cnt_q     <= sat_add(wr_cnt_q, EVT_W'(wr_done));
            drop_cnt_q   <= sat_add(drop_cnt_q, n_drop);
            rej_cnt_q    <= sat_add(rej_cnt_q, n_rej);
            for (int i = 0; i < IF_COUNT; i++) begin
                if (cap_ok[i]) begin
                    slot_s_q[i]  <= cap_s[i];
                    slot_ns_q[i] <= cap_ns[i];
                end
            end
        end
    end

`ifdef TIME_SYNC_PHC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
    assign stat_timeout = tmo_q;
`else
    assign stat_timeout = 1'b0;
`endif

    assign time_sync_wr_en   = wr_en_q;
    assign time_sync_wr_ns   = wr_ns_q;
    assign time_sync_wr_s    = wr_s_q;
    assign busy              = (state_q != IDLE) || (|pending_q);
    assign stat_wr_count     = wr_cnt_q;
    assign stat_drop_count   = drop_cnt_q;
    assign stat_reject_count = rej_cnt_q;
endmodule

// File: tb/tb_time_sync_phc_arb.sv
// Bench for time_sync_phc_arb: vector table, directed corner sequences, random run vs model.
module tb_time_sync_phc_arb;
    localparam int IFN  = 2;
    localparam int HOLD = 16;
    localparam int TMO  = 8;
    localparam int CW   = 5;
    localparam int CMAX = 2**CW - 1;
`ifdef TIME_SYNC_PHC_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IFN-1:0]    sync_wr_en;
    logic [IFN*96-1:0] sync_wr_ts;
    logic              wr_en, ack, busy, tmo;
    logic [29:0]       wr_ns;
    logic [47:0]       wr_s;
    logic [CW-1:0]     wr_cnt, drop_cnt, rej_cnt;
    int                tests = 0, fails = 0;

    always #5 clk = ~clk;

    time_sync_phc_arb #(.IF_COUNT(IFN), .HOLDOFF_CYCLES(HOLD), .ACK_TIMEOUT_CYCLES(TMO),
                        .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sync_wr_en(sync_wr_en), .sync_wr_ts(sync_wr_ts),
        .time_sync_wr_en(wr_en), .time_sync_wr_ns(wr_ns), .time_sync_wr_s(wr_s),
        .time_sync_wr_ack(ack), .busy(busy), .stat_wr_count(wr_cnt),
        .stat_drop_count(drop_cnt), .stat_reject_count(rej_cnt), .stat_timeout(tmo));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fns and bits [47:46] are random junk the DUT must ignore
    task automatic put(input int idx, input logic [47:0] s, input logic [29:0] ns);
        logic [1:0]  j2;
        logic [15:0] fns;
        j2  = 2'($urandom);
        fns = 16'($urandom);
        sync_wr_en[idx] = 1'b1;
        sync_wr_ts[idx*96 +: 96] = {s, j2, ns, fns};
    endtask

    task automatic clr();
        sync_wr_en = '0;
    endtask

    task automatic ack_drain();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic do_reset();
        clr();
        ack   = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_ns", wr_ns, 0);
        check("rst_s", wr_s, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_rej", rej_cnt, 0);
        check("rst_tmo", tmo, 0);
    endtask

    // ---------------- reference model ----------------
    bit          m_pend[IFN];
    logic [47:0] m_slot_s[IFN];
    logic [29:0] m_slot_ns[IFN];
    int          m_last, m_hold, m_wait, m_wrc, m_drop, m_rej;
    bit          m_wr, m_tmo;
    logic [29:0] m_ns;
    logic [47:0] m_s;

    function automatic int satc(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_init();
        for (int i = 0; i < IFN; i++) m_pend[i] = 1'b0;
        m_last = IFN - 1; m_hold = 0; m_wait = 0;
        m_wrc = 0; m_drop = 0; m_rej = 0;
        m_wr = 1'b0; m_tmo = 1'b0; m_ns = '0; m_s = '0;
    endtask

    // One clock edge: write port first (ack, timeout, hold-off, grant), then captures.
    task automatic model_step();
        int gi, j;
        logic [29:0] ns;
        gi = -1;
        m_tmo = 1'b0;
        if (m_wr) begin
            if (ack) begin
                m_wr = 1'b0; m_wrc = satc(m_wrc + 1); m_hold = HOLD;
            end else begin
                m_wait++;
                if (TMO_EN && m_wait >= TMO) begin
                    m_wr = 1'b0; m_tmo = 1'b1; m_hold = HOLD;
                end
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            for (int k = 1; k <= IFN; k++) begin
                j = (m_last + k) % IFN;
                if (gi < 0 && m_pend[j]) gi = j;
            end
            if (gi >= 0) begin
                m_wr = 1'b1; m_wait = 0; m_last = gi; m_pend[gi] = 1'b0;
                m_ns = m_slot_ns[gi]; m_s = m_slot_s[gi];
            end
        end
        for (int i = 0; i < IFN; i++) begin
            if (sync_wr_en[i]) begin
                ns = sync_wr_ts[i*96+16 +: 30];
                if (ns < 30'd1_000_000_000) begin
                    if (m_pend[i]) m_drop = satc(m_drop + 1);
                    m_pend[i]    = 1'b1;
                    m_slot_ns[i] = ns;
                    m_slot_s[i]  = sync_wr_ts[i*96+48 +: 48];
                end else begin
                    m_rej = satc(m_rej + 1);
                end
            end
        end
    endtask

    task automatic model_cmp();
        bit any;
        any = m_wr || (m_hold > 0);
        for (int i = 0; i < IFN; i++) any |= m_pend[i];
        check("rnd_wr_en", wr_en, m_wr);
        check("rnd_ns", wr_ns, m_ns);
        check("rnd_s", wr_s, m_s);
        check("rnd_busy", busy, any);
        check("rnd_wr_cnt", wr_cnt, m_wrc);
        check("rnd_drop", drop_cnt, m_drop);
        check("rnd_rej", rej_cnt, m_rej);
        check("rnd_tmo", tmo, m_tmo);
    endtask

    typedef struct {
        int          ifx;
        logic [47:0] s;
        logic [29:0] ns;
        bit          ok;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rej_exp, wr_exp;
        tbl[0] = '{0, 48'h1,            30'd0,             1'b1};
        tbl[1] = '{1, 48'hABCD_0123,    30'd999_999_999,   1'b1};
        tbl[2] = '{0, 48'd7,            30'd1_000_000_000, 1'b0};
        tbl[3] = '{1, 48'hFFFF_FFFF_FFFF, 30'h3FFF_FFFF,   1'b0};
        tbl[4] = '{1, 48'd123,          30'd1,             1'b1};
        tbl[5] = '{0, 48'd9,            30'd1_000_000_001, 1'b0};

        sync_wr_en = '0; sync_wr_ts = '0; ack = 1'b0; rst_n = 1'b0;
        do_reset();

        // stray ack while idle is ignored
        ack = 1'b1; tick(); ack = 1'b0;
        check("stray_ack_cnt", wr_cnt, 0);
        check("stray_ack_busy", busy, 0);

        // single request, 2-cycle latency, hold-off length
        put(0, 48'd5, 30'd100); tick(); clr();
        check("t1_lat_wr_en", wr_en, 0);
        check("t1_lat_busy", busy, 1);
        tick();
        check("t1_wr_en", wr_en, 1);
        check("t1_s", wr_s, 5);
        check("t1_ns", wr_ns, 100);
        tick(); tick();
        check("t1_hold_wr_en", wr_en, 1);
        ack = 1'b1; tick(); ack = 1'b0;
        check("t1_ack_wr_en", wr_en, 0);
        check("t1_wr_cnt", wr_cnt, 1);
        repeat (HOLD - 1) tick();
        check("t1_gap_busy", busy, 1);
        tick();
        check("t1_idle_busy", busy, 0);
        check("t1_ns_kept", wr_ns, 100);

        // round robin on simultaneous pairs
        do_reset();
        put(0, 48'd7, 30'd200); put(1, 48'd8, 30'd300); tick(); clr(); tick();
        check("rr1_ns", wr_ns, 200);
        check("rr1_s", wr_s, 7);
        ack_drain();
        check("rr_holdoff_wr_en", wr_en, 0);
        tick();
        check("rr2_wr_en", wr_en, 1);
        check("rr2_ns", wr_ns, 300);
        check("rr2_s", wr_s, 8);
        ack_drain(); tick();
        check("rr2_busy", busy, 0);
        put(0, 48'd9, 30'd400); put(1, 48'd10, 30'd500); tick(); clr(); tick();
        check("rr3_ns", wr_ns, 400);
        ack_drain(); tick();
        check("rr4_ns", wr_ns, 500);
        check("rr4_wr_cnt", wr_cnt, 3);

        // newest wins while busy
        do_reset();
        put(0, 48'd1, 30'd1); tick(); clr(); tick();
        put(1, 48'd2, 30'd10); tick();
        put(1, 48'd2, 30'd20); tick(); clr();
        check("drop_cnt", drop_cnt, 1);
        ack_drain(); tick();
        check("drop_wr_en", wr_en, 1);
        check("drop_ns", wr_ns, 20);

        // capture and grant on the same slot in the same cycle
        do_reset();
        put(0, 48'd3, 30'd10); tick();
        put(0, 48'd3, 30'd20); tick(); clr();
        check("same_ns_old", wr_ns, 10);
        check("same_drop", drop_cnt, 0);
        check("same_busy", busy, 1);
        ack_drain(); tick();
        check("same_wr_en_new", wr_en, 1);
        check("same_ns_new", wr_ns, 20);

        // ack timeout behaviour
        do_reset();
        put(0, 48'd4, 30'd55); tick(); clr(); tick();
`ifdef TIME_SYNC_PHC_TIMEOUT_EN
        repeat (TMO - 1) tick();
        check("tmo_pre_wr_en", wr_en, 1);
        check("tmo_pre_pulse", tmo, 0);
        tick();
        check("tmo_wr_en", wr_en, 0);
        check("tmo_pulse", tmo, 1);
        check("tmo_wr_cnt", wr_cnt, 0);
        tick();
        check("tmo_pulse_end", tmo, 0);
        check("tmo_gap_busy", busy, 1);
        repeat (HOLD - 1) tick();
        check("tmo_idle_busy", busy, 0);
`else
        repeat (40) tick();
        check("notmo_wr_en", wr_en, 1);
        check("notmo_pulse", tmo, 0);
        check("notmo_ns", wr_ns, 55);
        ack = 1'b1; tick(); ack = 1'b0;
        check("notmo_wr_cnt", wr_cnt, 1);
`endif

        // reset in the middle of a write
        do_reset();
        put(0, 48'd0, 30'd1_000_000_000); tick(); clr();
        check("mid_rej", rej_cnt, 1);
        put(0, 48'd5, 30'd60); put(1, 48'd6, 30'd70); tick(); clr(); tick();
        check("mid_wr_en", wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_wr_en", wr_en, 0);
        check("mid_async_busy", busy, 0);
        check("mid_async_rej", rej_cnt, 0);
        check("mid_async_ns", wr_ns, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) tick();
        check("mid_after_wr_en", wr_en, 0);
        check("mid_after_busy", busy, 0);

        // table of capture-validation vectors
        do_reset();
        rej_exp = 0; wr_exp = 0;
        for (int v = 0; v < 6; v++) begin
            put(tbl[v].ifx, tbl[v].s, tbl[v].ns); tick(); clr(); tick();
            check("tbl_wr_en", wr_en, tbl[v].ok);
            check("tbl_busy", busy, tbl[v].ok);
            if (tbl[v].ok) begin
                check("tbl_ns", wr_ns, tbl[v].ns);
                check("tbl_s", wr_s, tbl[v].s);
                ack_drain();
                wr_exp++;
            end else begin
                rej_exp++;
            end
            check("tbl_rej", rej_cnt, rej_exp);
            check("tbl_wr_cnt", wr_cnt, wr_exp);
            check("tbl_idle", busy, 0);
        end

        // random run against the model; small counters so saturation is exercised
        do_reset();
        model_init();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < IFN; i++) begin
                int r;
                logic [29:0] ns;
                sync_wr_en[i] = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 9);
                    if (r < 7)       ns = 30'($urandom_range(0, 999_999_999));
                    else if (r == 7) ns = 30'd999_999_999;
                    else if (r == 8) ns = 30'd1_000_000_000;
                    else             ns = 30'($urandom_range(1_000_000_000, 1_073_741_823));
                    put(i, 48'({$urandom, $urandom}), ns);
                end
            end
            ack = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step();
            #1;
            model_cmp();
        end
        clr();
        ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
